regfile_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the memory-mapped chip/GPIO register file.
- Shares that block's single addr/wben/r_wn/wdata/rdata port between the core load/store unit (m0) and the debug port (m1).
- Runs one transaction at a time, using round-robin (or fixed-priority) arbitration.
- Keeps the register port idle-safe: the register file writes on every cycle where r_wn=0, so the arbiter drives a write for exactly one cycle per granted write and nowhere else.

---
 rtl/regfile_arbiter.sv | 165 ++++++++++++++++
 tb/tb_regfile_arbiter.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares the register file port between the core LSU (m0)
// and the debug port (m1), one transaction at a time.
//
// state      | meaning
// ST_IDLE    | port idle; arbitrate and latch a command when any req is high
// ST_ISSUE   | command on the register port for exactly this cycle
// ST_CAPTURE | reg_rdata valid; complete the granted requester on the closing edge
module regfile_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_m0_req,
    input  logic [2:0]  i_m0_addr,
    input  logic        i_m0_r_wn,
    input  logic [3:0]  i_m0_wben,
    input  logic [31:0] i_m0_wdata,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    output logic [31:0] o_m0_rdata,
    input  logic        i_m1_req,
    input  logic [2:0]  i_m1_addr,
    input  logic        i_m1_r_wn,
    input  logic [3:0]  i_m1_wben,
    input  logic [31:0] i_m1_wdata,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic [31:0] o_m1_rdata,
    output logic [2:0]  o_reg_addr,
    output logic        o_reg_r_wn,
    output logic [3:0]  o_reg_wben,
    output logic [31:0] o_reg_wdata,
    input  logic [31:0] i_reg_rdata,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_m1;
    logic        r_gnt_m1;
    logic        r_rej;
    logic        r_rd;

    logic        w_pick_m1;
    logic        w_grant;
    logic        w_rej;
    logic [2:0]  w_addr;
    logic        w_r_wn;
    logic [3:0]  w_wben;
    logic [31:0] w_wdata;

    // Arbitration, command select and access legality check.
    always_comb begin
        w_pick_m1 = 1'b0;
        if (i_m0_req && i_m1_req) begin
            w_pick_m1 = (FIXED_PRIO == 0) ? !r_last_m1 : 1'b0;
        end else begin
            w_pick_m1 = i_m1_req;
        end
        w_addr  = w_pick_m1 ? i_m1_addr  : i_m0_addr;
        w_r_wn  = w_pick_m1 ? i_m1_r_wn  : i_m0_r_wn;
        w_wben  = w_pick_m1 ? i_m1_wben  : i_m0_wben;
        w_wdata = w_pick_m1 ? i_m1_wdata : i_m0_wdata;
        // Read-only registers (0, 1, 3) refuse writes; 7 is unmapped entirely.
        if (w_r_wn) begin
            w_rej = (w_addr == 3'd7);
        end else begin
            w_rej = (w_addr == 3'd0) || (w_addr == 3'd1) ||
                    (w_addr == 3'd3) || (w_addr == 3'd7);
        end
        w_grant = (r_state == ST_IDLE) && (i_m0_req || i_m1_req);
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_grant) w_state_nxt = ST_ISSUE;
            ST_ISSUE:   w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the winner, its reject flag and direction at grant time.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_last_m1 <= 1'b1;
            r_gnt_m1  <= 1'b0;
            r_rej     <= 1'b0;
            r_rd      <= 1'b1;
        end else if (w_grant) begin
            r_last_m1 <= w_pick_m1;
            r_gnt_m1  <= w_pick_m1;
            r_rej     <= w_rej;
            r_rd      <= w_r_wn;
        end
    end

    // Register port: idle read of addr 0 except the single ISSUE cycle of a legal command.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_reg_addr  <= 3'd0;
            o_reg_r_wn  <= 1'b1;
            o_reg_wben  <= 4'd0;
            o_reg_wdata <= 32'd0;
        end else if (w_grant && !w_rej) begin
            o_reg_addr  <= w_addr;
            o_reg_r_wn  <= w_r_wn;
            o_reg_wben  <= w_wben;
            o_reg_wdata <= w_wdata;
        end else begin
            o_reg_addr  <= 3'd0;
            o_reg_r_wn  <= 1'b1;
            o_reg_wben  <= 4'd0;
            o_reg_wdata <= 32'd0;
        end
    end

    // Completion: one-cycle ack/err pulse and read data capture for the granted requester.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_m0_ack   <= 1'b0;
            o_m0_err   <= 1'b0;
            o_m0_rdata <= 32'd0;
            o_m1_ack   <= 1'b0;
            o_m1_err   <= 1'b0;
            o_m1_rdata <= 32'd0;
        end else begin
            o_m0_ack <= 1'b0;
            o_m0_err <= 1'b0;
            o_m1_ack <= 1'b0;
            o_m1_err <= 1'b0;
            if (r_state == ST_CAPTURE) begin
                if (r_gnt_m1) begin
                    o_m1_ack <= 1'b1;
                    o_m1_err <= r_rej;
                    if (r_rd) o_m1_rdata <= r_rej ? 32'd0 : i_reg_rdata;
                end else begin
                    o_m0_ack <= 1'b1;
                    o_m0_err <= r_rej;
                    if (r_rd) o_m0_rdata <= r_rej ? 32'd0 : i_reg_rdata;
                end
            end
        end
    end

    assign o_busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: instance 0 is round-robin, instance 1 fixed priority.
// Each instance talks to its own small register file model.
module tb_regfile_arbiter;

    localparam logic [31:0] NAME_VAL = 32'h48524a44;
    localparam logic [31:0] VER_VAL  = 32'h0001_0003;
    localparam logic [31:0] PIN_VAL  = 32'h5a5a_c3c3;

    typedef struct {
        int          cyc;
        int          m;
        logic        e;
        logic [31:0] rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [1:0][1:0]        req;
    logic [1:0][1:0]        rwn;
    logic [1:0][1:0][2:0]   addr;
    logic [1:0][1:0][3:0]   wben;
    logic [1:0][1:0][31:0]  wdata;
    logic [1:0][1:0]        ack;
    logic [1:0][1:0]        err;
    logic [1:0][1:0][31:0]  rdata;

    logic [1:0][2:0]        p_addr;
    logic [1:0]             p_rwn;
    logic [1:0][3:0]        p_wben;
    logic [1:0][31:0]       p_wdata;
    logic [1:0][31:0]       p_rdata;
    logic [1:0]             busy;

    int total = 0;
    int bad   = 0;
    int wcnt [2] = '{0, 0};

    logic [1:0][7:0][31:0]  env_mem = '0;
    logic [1:0][7:0][31:0]  ref_mem = '0;
    logic [1:0][1:0][31:0]  ref_rdata = '0;
    int                     ref_last [2] = '{1, 1};

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < 2; g++) begin : g_dut
        regfile_arbiter #(.FIXED_PRIO(g)) u_dut (
            .i_clk       (clk),
            .i_reset     (rst),
            .i_m0_req    (req[g][0]),
            .i_m0_addr   (addr[g][0]),
            .i_m0_r_wn   (rwn[g][0]),
            .i_m0_wben   (wben[g][0]),
            .i_m0_wdata  (wdata[g][0]),
            .o_m0_ack    (ack[g][0]),
            .o_m0_err    (err[g][0]),
            .o_m0_rdata  (rdata[g][0]),
            .i_m1_req    (req[g][1]),
            .i_m1_addr   (addr[g][1]),
            .i_m1_r_wn   (rwn[g][1]),
            .i_m1_wben   (wben[g][1]),
            .i_m1_wdata  (wdata[g][1]),
            .o_m1_ack    (ack[g][1]),
            .o_m1_err    (err[g][1]),
            .o_m1_rdata  (rdata[g][1]),
            .o_reg_addr  (p_addr[g]),
            .o_reg_r_wn  (p_rwn[g]),
            .o_reg_wben  (p_wben[g]),
            .o_reg_wdata (p_wdata[g]),
            .i_reg_rdata (p_rdata[g]),
            .o_busy      (busy[g])
        );
    end

    // Register file model: writes whenever r_wn=0, registered read data.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (p_rwn[d] == 1'b0) begin
                for (int b = 0; b < 4; b++) begin
                    if (p_wben[d][b]) env_mem[d][p_addr[d]][8*b +: 8] <= p_wdata[d][8*b +: 8];
                end
            end
            case (p_addr[d])
                3'd0:    p_rdata[d] <= NAME_VAL;
                3'd1:    p_rdata[d] <= VER_VAL;
                3'd3:    p_rdata[d] <= PIN_VAL;
                3'd7:    p_rdata[d] <= 32'd0;
                default: p_rdata[d] <= env_mem[d][p_addr[d]];
            endcase
        end
    end

    // Count port write cycles and flag simultaneous acks.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (p_rwn[d] == 1'b0) wcnt[d]++;
            if (ack[d][0] === 1'b1 && ack[d][1] === 1'b1) begin
                bad++;
                $display("FAIL ack_overlap d=%0d got=both_acks expected=at_most_one", d);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic is_rej(logic [2:0] a, logic rw);
        if (rw) return (a == 3'd7);
        return (a == 3'd0) || (a == 3'd1) || (a == 3'd3) || (a == 3'd7);
    endfunction

    function automatic logic [31:0] ref_read(int d, logic [2:0] a);
        case (a)
            3'd0:    return NAME_VAL;
            3'd1:    return VER_VAL;
            3'd3:    return PIN_VAL;
            3'd7:    return 32'd0;
            default: return ref_mem[d][a];
        endcase
    endfunction

    // Instance 1 is fixed priority; instance 0 alternates on ties.
    function automatic int winner(int d, logic p0, logic p1);
        if (p0 && p1) begin
            if (d == 1) return 0;
            return (ref_last[d] == 1) ? 0 : 1;
        end
        return p0 ? 0 : 1;
    endfunction

    // Apply the command currently presented by requester m and return its expected result.
    task automatic ref_txn(input int d, input int m, output logic e, output logic [31:0] rd);
        logic [2:0] a;
        a = addr[d][m];
        e = is_rej(a, rwn[d][m]);
        if (rwn[d][m]) begin
            rd = e ? 32'd0 : ref_read(d, a);
            ref_rdata[d][m] = rd;
        end else begin
            rd = ref_rdata[d][m];
            if (!e) begin
                for (int b = 0; b < 4; b++) begin
                    if (wben[d][m][b]) ref_mem[d][a][8*b +: 8] = wdata[d][m][8*b +: 8];
                end
            end
        end
        ref_last[d] = m;
    endtask

    task automatic set_cmd(input int d, input int m, input logic r, input logic [2:0] a,
                           input logic rw, input logic [3:0] be, input logic [31:0] wd);
        req[d][m]   = r;
        addr[d][m]  = a;
        rwn[d][m]   = rw;
        wben[d][m]  = be;
        wdata[d][m] = wd;
    endtask

    task automatic wait_ack(input int d, input int m, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack[d][m] !== 1'b1 && n < 12);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ref_last[d]  = 1;
            ref_rdata[d] = '0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic seen;
        total++;
        if ({p_addr[0], p_rwn[0], p_wben[0], p_wdata[0]} !== {3'd0, 1'b1, 4'd0, 32'd0})
            $display("FAIL reset_port got=%h expected=%h", {p_addr[0], p_rwn[0], p_wben[0], p_wdata[0]},
                     {3'd0, 1'b1, 4'd0, 32'd0});
        else total += 0;
        if ({p_addr[0], p_rwn[0], p_wben[0], p_wdata[0]} !== {3'd0, 1'b1, 4'd0, 32'd0}) bad++;
        total++;
        if ({busy[0], ack[0], err[0], rdata[0]} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h expected=0", {busy[0], ack[0], err[0], rdata[0]});
        end
        set_cmd(0, 0, 1'b1, 3'd5, 1'b0, 4'hF, 32'h1234_5678);
        @(negedge clk);
        total++;
        if ({p_addr[0], p_rwn[0], p_wben[0], busy[0]} !== {3'd5, 1'b0, 4'hF, 1'b1}) begin
            bad++;
            $display("FAIL reset_issue_port got=%h expected=%h", {p_addr[0], p_rwn[0], p_wben[0], busy[0]},
                     {3'd5, 1'b0, 4'hF, 1'b1});
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({p_rwn[0], p_wben[0], busy[0]} !== {1'b1, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_async got=%h expected=%h", {p_rwn[0], p_wben[0], busy[0]}, {1'b1, 4'd0, 1'b0});
        end
        @(negedge clk);
        req = '0;
        rst = 1'b0;
        ref_last[0]  = 1;
        ref_rdata[0] = '0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack[0] !== 2'b00) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_ack got=ack_seen expected=none");
        end
    endtask

    task automatic test_read();
        int n;
        logic e;
        logic [31:0] rd;
        set_cmd(0, 0, 1'b1, 3'd0, 1'b1, 4'h0, 32'h0);
        wait_ack(0, 0, n);
        ref_txn(0, 0, e, rd);
        total++;
        if (n !== 3) begin bad++; $display("FAIL read_latency got=%0d expected=3", n); end
        total++;
        if (rdata[0][0] !== rd) begin bad++; $display("FAIL read_data got=%h expected=%h", rdata[0][0], rd); end
        total++;
        if (err[0][0] !== e) begin bad++; $display("FAIL read_err got=%b expected=%b", err[0][0], e); end
        req[0][0] = 1'b0;
        @(negedge clk);
        total++;
        if (ack[0][0] !== 1'b0) begin bad++; $display("FAIL ack_width got=%b expected=0", ack[0][0]); end
    endtask

    task automatic test_write_read();
        int n, w0;
        logic e;
        logic [31:0] rd;
        w0 = wcnt[0];
        set_cmd(0, 1, 1'b1, 3'd6, 1'b0, 4'hF, 32'hDEADBEEF);
        wait_ack(0, 1, n);
        ref_txn(0, 1, e, rd);
        total++;
        if (n !== 3 || err[0][1] !== e) begin
            bad++;
            $display("FAIL write_ack got=n%0d/err%b expected=n3/err%b", n, err[0][1], e);
        end
        set_cmd(0, 1, 1'b1, 3'd6, 1'b1, 4'h0, 32'h0);
        wait_ack(0, 1, n);
        ref_txn(0, 1, e, rd);
        total++;
        if (n !== 3) begin bad++; $display("FAIL readback_latency got=%0d expected=3", n); end
        total++;
        if (rdata[0][1] !== rd) begin bad++; $display("FAIL readback_data got=%h expected=%h", rdata[0][1], rd); end
        req[0][1] = 1'b0;
        @(negedge clk);
        total++;
        if (wcnt[0] - w0 !== 1) begin bad++; $display("FAIL write_pulses got=%0d expected=1", wcnt[0] - w0); end
    endtask

    task automatic test_rejects();
        int n, w0;
        logic e;
        logic [31:0] rd;
        w0 = wcnt[0];
        set_cmd(0, 0, 1'b1, 3'd1, 1'b0, 4'hF, 32'h1111_2222);
        wait_ack(0, 0, n);
        ref_txn(0, 0, e, rd);
        total++;
        if (n !== 3 || err[0][0] !== e) begin
            bad++;
            $display("FAIL reject_write got=n%0d/err%b expected=n3/err%b", n, err[0][0], e);
        end
        set_cmd(0, 0, 1'b1, 3'd7, 1'b1, 4'h0, 32'h0);
        wait_ack(0, 0, n);
        ref_txn(0, 0, e, rd);
        total++;
        if (n !== 3 || err[0][0] !== e) begin
            bad++;
            $display("FAIL reject_read got=n%0d/err%b expected=n3/err%b", n, err[0][0], e);
        end
        total++;
        if (rdata[0][0] !== rd) begin bad++; $display("FAIL reject_rdata got=%h expected=%h", rdata[0][0], rd); end
        req[0][0] = 1'b0;
        @(negedge clk);
        total++;
        if (wcnt[0] - w0 !== 0) begin bad++; $display("FAIL reject_port got=%0d expected=0", wcnt[0] - w0); end
    endtask

    task automatic test_back_to_back();
        int n;
        logic e;
        logic [31:0] rd;
        set_cmd(0, 0, 1'b1, 3'd4, 1'b1, 4'h0, 32'h0);
        wait_ack(0, 0, n);
        ref_txn(0, 0, e, rd);
        set_cmd(0, 0, 1'b1, 3'd2, 1'b0, 4'h1, 32'hCAFE_F00D);
        wait_ack(0, 0, n);
        ref_txn(0, 0, e, rd);
        total++;
        if (n !== 3 || err[0][0] !== e) begin
            bad++;
            $display("FAIL b2b_write got=n%0d/err%b expected=n3/err%b", n, err[0][0], e);
        end
        set_cmd(0, 0, 1'b1, 3'd2, 1'b1, 4'h0, 32'h0);
        wait_ack(0, 0, n);
        ref_txn(0, 0, e, rd);
        total++;
        if (n !== 3) begin bad++; $display("FAIL b2b_latency got=%0d expected=3", n); end
        total++;
        if (rdata[0][0] !== rd) begin bad++; $display("FAIL b2b_readback got=%h expected=%h", rdata[0][0], rd); end
        req[0][0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tie(input int d);
        int n, w;
        logic e;
        logic [31:0] rd;
        do_reset();
        set_cmd(d, 0, 1'b1, 3'($urandom_range(0, 6)), 1'b1, 4'h0, 32'h0);
        set_cmd(d, 1, 1'b1, 3'($urandom_range(0, 6)), 1'b1, 4'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            w = winner(d, req[d][0], req[d][1]);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (ack[d][0] !== 1'b1 && ack[d][1] !== 1'b1 && n < 12);
            total++;
            if (n !== 3) begin bad++; $display("FAIL tie_spacing d=%0d i=%0d got=%0d expected=3", d, i, n); end
            total++;
            if (ack[d][w] !== 1'b1) begin
                bad++;
                $display("FAIL tie_grant d=%0d i=%0d got=acks%b expected=m%0d", d, i, ack[d], w);
            end
            ref_txn(d, w, e, rd);
            total++;
            if (rdata[d][w] !== rd) begin
                bad++;
                $display("FAIL tie_rdata d=%0d i=%0d got=%h expected=%h", d, i, rdata[d][w], rd);
            end
            if (i < 3) set_cmd(d, w, 1'b1, 3'($urandom_range(0, 6)), 1'b1, 4'h0, 32'h0);
            else req[d][w] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_random(input int d, input int ncyc);
        exp_t q[$];
        exp_t t;
        logic [1:0] pend;
        logic ex, e;
        logic [31:0] rd;
        int next_ok, nwr, w0, w;
        pend = 2'b00;
        next_ok = 0;
        nwr = 0;
        w0 = wcnt[d];
        for (int k = 0; k < ncyc + 40; k++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                ex = (q.size() > 0) && (q[0].cyc == k) && (q[0].m == m);
                total++;
                if (ack[d][m] !== ex) begin
                    bad++;
                    $display("FAIL rand_ack d=%0d k=%0d m=%0d got=%b expected=%b", d, k, m, ack[d][m], ex);
                end else if (ex) begin
                    total++;
                    if (err[d][m] !== q[0].e) begin
                        bad++;
                        $display("FAIL rand_err d=%0d k=%0d m=%0d got=%b expected=%b", d, k, m, err[d][m], q[0].e);
                    end
                    total++;
                    if (rdata[d][m] !== q[0].rd) begin
                        bad++;
                        $display("FAIL rand_rdata d=%0d k=%0d m=%0d got=%h expected=%h", d, k, m, rdata[d][m], q[0].rd);
                    end
                end
                if (ex) pend[m] = 1'b0;
            end
            if (q.size() > 0 && q[0].cyc == k) void'(q.pop_front());
            for (int m = 0; m < 2; m++) begin
                if (!pend[m]) begin
                    if (k < ncyc && $urandom_range(0, 2) != 0) begin
                        set_cmd(d, m, 1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                                4'($urandom), $urandom);
                        pend[m] = 1'b1;
                    end else begin
                        req[d][m] = 1'b0;
                    end
                end
            end
            // A grant happens on the next edge whenever the port is free and someone waits.
            if (k >= next_ok && pend != 2'b00) begin
                w = winner(d, pend[0], pend[1]);
                ref_txn(d, w, e, rd);
                t.cyc = k + 3;
                t.m   = w;
                t.e   = e;
                t.rd  = rd;
                q.push_back(t);
                next_ok = k + 3;
                if (!rwn[d][w] && !e) nwr++;
            end
            if (k >= ncyc && pend == 2'b00 && q.size() == 0) break;
        end
        req[d] = 2'b00;
        @(negedge clk);
        total++;
        if (pend !== 2'b00) begin bad++; $display("FAIL rand_drain d=%0d got=%b expected=00", d, pend); end
        total++;
        if (wcnt[d] - w0 !== nwr) begin
            bad++;
            $display("FAIL rand_writes d=%0d got=%0d expected=%0d", d, wcnt[d] - w0, nwr);
        end
    endtask

    initial begin
        req   = '0;
        addr  = '0;
        rwn   = '1;
        wben  = '0;
        wdata = '0;
        do_reset();
        test_reset();
        test_read();
        test_write_read();
        test_rejects();
        test_back_to_back();
        test_tie(0);
        test_tie(1);
        test_random(0, 150);
        test_random(1, 100);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
